// File: rtl/ultrasonic_ranger_if.sv
// Sensor-pin and distance-result bundle between the ranger and its neighbours.
// The ranger takes the slave modport; the sensor model/consumer side takes master.
interface ultrasonic_ranger_if #(
  parameter int CNT_W  = 24,
  parameter int DIST_W = 16
);
  logic              ECHO;
  logic              TRIGGER;
  logic [CNT_W-1:0]  echo_cycles;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              timeout;
  logic              busy;

  // dist_valid is a one-cycle strobe with no ready: the consumer must take
  // echo_cycles/dist_cm/timeout in that cycle; they then hold until the next strobe.
  modport slave (
    input  ECHO,
    output TRIGGER, echo_cycles, dist_cm, dist_valid, timeout, busy
  );

  modport master (
    output ECHO,
    input  TRIGGER, echo_cycles, dist_cm, dist_valid, timeout, busy
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, synchronised echo timing, cm conversion.
// Optional RANGER_MEDIAN3_EN adds a 3-tap median on dist_cm (one extra cycle of lag).
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES         = 500,
  parameter int MEAS_PERIOD_CYCLES  = 3_000_000,
  parameter int ECHO_TIMEOUT_CYCLES = 1_250_000,
  parameter int CYCLES_PER_CM       = 2900,
  parameter int CNT_W               = 24,
  parameter int DIST_W              = 16
) (
  input  logic                clk,
  input  logic                rst,
  ultrasonic_ranger_if.slave  io_rng,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_PERIOD_LAST = CNT_W'(MEAS_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST     = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO          = CNT_W'(ECHO_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LP_CPC_LAST    = CNT_W'(CYCLES_PER_CM - 1);

  state_t              r_state;
  logic                r_sync1;
  logic                r_echo_s;
  logic                r_echo_d;
  logic                r_trigger;
  logic                r_busy;
  logic [CNT_W-1:0]    r_period;
  logic [CNT_W-1:0]    r_wait;
  logic [CNT_W-1:0]    r_echo_cnt;
  logic [CNT_W-1:0]    r_presc;
  logic [DIST_W-1:0]   r_cm;
  logic                r_res_valid;
  logic [CNT_W-1:0]    r_res_cycles;
  logic [DIST_W-1:0]   r_res_cm;
  logic                r_res_to;

  logic                w_echo_rise;
  logic [DIST_W-1:0]   w_cm_final;

  assign w_echo_rise = r_echo_s & ~r_echo_d;

  // The echo counter counts the rise cycle too, so it leads the prescaler by one;
  // a prescaler sitting on its last value therefore completes one more centimetre.
  assign w_cm_final = ((r_presc == LP_CPC_LAST) && (r_cm != '1)) ? r_cm + 1'b1 : r_cm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      r_sync1  <= io_rng.ECHO;
      r_echo_s <= r_sync1;
      r_echo_d <= r_echo_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trigger    <= 1'b0;
      r_busy       <= 1'b0;
      r_period     <= '0;
      r_wait       <= '0;
      r_echo_cnt   <= '0;
      r_presc      <= '0;
      r_cm         <= '0;
      r_res_valid  <= 1'b0;
      r_res_cycles <= '0;
      r_res_cm     <= '0;
      r_res_to     <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (r_period != LP_PERIOD_LAST) r_period <= r_period + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_state   <= S_TRIG;
          r_trigger <= 1'b1;
          r_busy    <= 1'b1;
          r_period  <= '0;
        end

        S_TRIG: begin
          if (r_period == LP_TRIG_LAST) begin
            r_state   <= S_WAIT_RISE;
            r_trigger <= 1'b0;
            r_wait    <= '0;
          end
        end

        S_WAIT_RISE: begin
          r_wait <= r_wait + 1'b1;
          if (w_echo_rise) begin
            r_state    <= S_MEASURE;
            r_echo_cnt <= CNT_W'(1);
            r_presc    <= '0;
            r_cm       <= '0;
          end else if (r_wait == LP_TO_LAST) begin
            r_state      <= S_HOLDOFF;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b1;
            r_res_cycles <= LP_TO;
            r_res_cm     <= '1;
            r_res_to     <= 1'b1;
          end
        end

        S_MEASURE: begin
          if (!r_echo_s) begin
            r_state      <= S_HOLDOFF;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b1;
            r_res_cycles <= r_echo_cnt;
            r_res_cm     <= w_cm_final;
            r_res_to     <= 1'b0;
          end else if (r_echo_cnt == LP_TO_LAST) begin
            r_state      <= S_HOLDOFF;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b1;
            r_res_cycles <= LP_TO;
            r_res_cm     <= '1;
            r_res_to     <= 1'b1;
          end else begin
            r_echo_cnt <= r_echo_cnt + 1'b1;
            if (r_presc == LP_CPC_LAST) begin
              r_presc <= '0;
              if (r_cm != '1) r_cm <= r_cm + 1'b1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
        end

        S_HOLDOFF: begin
          // A late echo from this ping must drain before the next trigger goes out.
          if ((r_period == LP_PERIOD_LAST) && !r_echo_s) begin
            r_state   <= S_TRIG;
            r_trigger <= 1'b1;
            r_busy    <= 1'b1;
            r_period  <= '0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_trigger <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign io_rng.TRIGGER = r_trigger;
  assign io_rng.busy    = r_busy;
  assign o_dbg_state    = r_state;

`ifdef RANGER_MEDIAN3_EN
  logic [DIST_W-1:0] r_h1;
  logic [DIST_W-1:0] r_h2;
  logic [1:0]        r_nres;
  logic              r_med_valid;
  logic [CNT_W-1:0]  r_med_cycles;
  logic [DIST_W-1:0] r_med_cm;
  logic              r_med_to;

  function automatic logic [DIST_W-1:0] f_median3(
    input logic [DIST_W-1:0] a,
    input logic [DIST_W-1:0] b,
    input logic [DIST_W-1:0] c
  );
    logic [DIST_W-1:0] lo;
    logic [DIST_W-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      return lo;
    else if (c > hi) return hi;
    else             return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h1         <= '0;
      r_h2         <= '0;
      r_nres       <= '0;
      r_med_valid  <= 1'b0;
      r_med_cycles <= '0;
      r_med_cm     <= '0;
      r_med_to     <= 1'b0;
    end else begin
      r_med_valid <= r_res_valid;
      if (r_res_valid) begin
        r_med_cycles <= r_res_cycles;
        r_med_to     <= r_res_to;
        r_med_cm     <= (r_nres < 2'd2) ? r_res_cm : f_median3(r_res_cm, r_h1, r_h2);
        r_h2         <= r_h1;
        r_h1         <= r_res_cm;
        if (r_nres != 2'd2) r_nres <= r_nres + 1'b1;
      end
    end
  end

  assign io_rng.dist_valid  = r_med_valid;
  assign io_rng.echo_cycles = r_med_cycles;
  assign io_rng.dist_cm     = r_med_cm;
  assign io_rng.timeout     = r_med_to;
`else
  assign io_rng.dist_valid  = r_res_valid;
  assign io_rng.echo_cycles = r_res_cycles;
  assign io_rng.dist_cm     = r_res_cm;
  assign io_rng.timeout     = r_res_to;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with shortened timing parameters; expected results come
// from echo width arithmetic (and a sorted 3-entry window when RANGER_MEDIAN3_EN is set).
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

  localparam int TRIG_CYCLES         = 20;
  localparam int MEAS_PERIOD_CYCLES  = 2000;
  localparam int ECHO_TIMEOUT_CYCLES = 700;
  localparam int CYCLES_PER_CM       = 29;
  localparam int CNT_W               = 24;
  localparam int DIST_W              = 16;
  localparam int W                   = CNT_W + DIST_W + 1;
  localparam int DIST_MAX            = (1 << DIST_W) - 1;
`ifdef RANGER_MEDIAN3_EN
  localparam int PUB_LAG = 1;
`else
  localparam int PUB_LAG = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ultrasonic_ranger_if #(.CNT_W(CNT_W), .DIST_W(DIST_W)) rng_if ();

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG_CYCLES),
    .MEAS_PERIOD_CYCLES(MEAS_PERIOD_CYCLES),
    .ECHO_TIMEOUT_CYCLES(ECHO_TIMEOUT_CYCLES),
    .CYCLES_PER_CM(CYCLES_PER_CM),
    .CNT_W(CNT_W),
    .DIST_W(DIST_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_rng(rng_if),
    .o_dbg_state(dbg_state)
  );

  initial begin
    #(90_000 * 20);
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  int          n_valid     = 0;
  int          t_last      = 0;
  logic [W-1:0] exp_q[$];
  int           raw_hist[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: width below the limit gives floor(width/cm), otherwise a timeout result.
  task automatic push_expected(input int width);
    int           cm;
    int           cycles;
    bit           to;
    int           win[$];
    logic [W-1:0] e;
    if (width >= ECHO_TIMEOUT_CYCLES) begin
      to = 1'b1; cycles = ECHO_TIMEOUT_CYCLES; cm = DIST_MAX;
    end else begin
      to = 1'b0; cycles = width; cm = width / CYCLES_PER_CM;
      if (cm > DIST_MAX) cm = DIST_MAX;
    end
`ifdef RANGER_MEDIAN3_EN
    raw_hist.push_back(cm);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    if (raw_hist.size() == 3) begin
      win = raw_hist;
      win.sort();
      cm = win[1];
    end
`endif
    e = {to, CNT_W'(cycles), DIST_W'(cm)};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && rng_if.dist_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_dist_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("echo_cycles", rng_if.echo_cycles, e[DIST_W +: CNT_W]);
        check("dist_cm", rng_if.dist_cm, e[DIST_W-1:0]);
        check("timeout", rng_if.timeout, e[W-1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rise(input int limit, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < limit) begin
      @(negedge clk);
      lat++;
      if (rng_if.TRIGGER) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Entered on the first negedge showing TRIGGER high; leaves on the first one showing it low.
  task automatic check_trig_pulse();
    int hi      = 1;
    int busy_lo = 0;
    if (!rng_if.busy) busy_lo++;
    while (hi < 4 * TRIG_CYCLES) begin
      @(negedge clk);
      if (!rng_if.TRIGGER) break;
      hi++;
      if (!rng_if.busy) busy_lo++;
    end
    check("trig_high_cycles", hi, TRIG_CYCLES);
    check("busy_during_trig", busy_lo, 0);
  endtask

  task automatic finish_period(input int nv0);
    int lat;
    bit ok;
    wait_rise(MEAS_PERIOD_CYCLES, lat, ok);
    check("next_trigger_seen", ok, 1);
    check("trigger_period", cyc - t_last, MEAS_PERIOD_CYCLES);
    t_last = cyc;
    check("valids_per_trigger", n_valid - nv0, 1);
    check_trig_pulse();
  endtask

  task automatic run_meas(input int d, input int w);
    int nv0;
    nv0 = n_valid;
    push_expected(w);
    repeat (d) @(negedge clk);
    rng_if.ECHO = 1'b1;
    repeat (w) @(negedge clk);
    rng_if.ECHO = 1'b0;
    finish_period(nv0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_trigger"}, rng_if.TRIGGER, 0);
    check({tag, "_dist_valid"}, rng_if.dist_valid, 0);
    check({tag, "_busy"}, rng_if.busy, 0);
    check({tag, "_echo_cycles"}, rng_if.echo_cycles, 0);
    check({tag, "_dist_cm"}, rng_if.dist_cm, 0);
    check({tag, "_timeout"}, rng_if.timeout, 0);
    check({tag, "_state_idle"}, dbg_state, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int widths[9];
    int lat;
    bit ok;
    int nv0;
    int c;
    int trig_hi;

    widths = '{59, 250, 100, 588, 1, CYCLES_PER_CM - 1, CYCLES_PER_CM,
               ECHO_TIMEOUT_CYCLES - 1, ECHO_TIMEOUT_CYCLES + 50};
    rng_if.ECHO = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    rst = 1'b0;
    wait_rise(10, lat, ok);
    check("first_trigger_seen", ok, 1);
    check("first_trigger_within_2", (lat <= 2), 1);
    t_last = cyc;
    check_trig_pulse();

    foreach (widths[i]) run_meas(100, widths[i]);

    for (int i = 0; i < 8; i++)
      run_meas($urandom_range(2, 100), $urandom_range(1, ECHO_TIMEOUT_CYCLES - 1));

    // Echo never returns.
    nv0 = n_valid;
    push_expected(ECHO_TIMEOUT_CYCLES);
    c = 0;
    while (!rng_if.dist_valid && c < 2 * ECHO_TIMEOUT_CYCLES) begin
      @(negedge clk);
      c++;
    end
    check("wait_timeout_latency", c, ECHO_TIMEOUT_CYCLES + PUB_LAG);
    check("busy_after_result", rng_if.busy, 0);
    finish_period(nv0);

    // Echo stuck high well past the period end.
    nv0 = n_valid;
    push_expected(ECHO_TIMEOUT_CYCLES + 1);
    repeat (10) @(negedge clk);
    rng_if.ECHO = 1'b1;
    trig_hi = 0;
    while (cyc - t_last < MEAS_PERIOD_CYCLES + 300) begin
      @(negedge clk);
      if (rng_if.TRIGGER) trig_hi++;
    end
    check("no_trigger_while_echo_high", trig_hi, 0);
    check("long_echo_valids", n_valid - nv0, 1);
    rng_if.ECHO = 1'b0;
    wait_rise(10, lat, ok);
    check("retrigger_seen", ok, 1);
    check("retrigger_within_3", (lat >= 1 && lat <= 3), 1);
    t_last = cyc;
    check_trig_pulse();

    // Reset in the middle of an echo.
    nv0 = n_valid;
    repeat (10) @(negedge clk);
    rng_if.ECHO = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    repeat (4) @(negedge clk);
    check("no_valid_across_reset", n_valid - nv0, 0);
    rng_if.ECHO = 1'b0;
    raw_hist.delete();
    rst = 1'b0;
    wait_rise(10, lat, ok);
    check("trigger_after_reset_seen", ok, 1);
    check("trigger_after_reset_within_2", (lat <= 2), 1);
    t_last = cyc;
    check_trig_pulse();
    run_meas(30, 300);

    repeat (5) @(negedge clk);
    check("expected_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
